// File: rtl/id_ex_decode_pkg.sv
// Shared decode constants: ALU operation codes, RV32 opcodes, writeback
// selects, immediate formats and the ID/EX register layout.
package id_ex_decode_pkg;

    // ALU operation codes, shared by the decoder and the ALU
    localparam logic [4:0] ALU_ADD  = 5'd0;
    localparam logic [4:0] ALU_SLL  = 5'd1;
    localparam logic [4:0] ALU_SLT  = 5'd2;
    localparam logic [4:0] ALU_SLTU = 5'd3;
    localparam logic [4:0] ALU_XOR  = 5'd4;
    localparam logic [4:0] ALU_SRL  = 5'd5;
    localparam logic [4:0] ALU_OR   = 5'd6;
    localparam logic [4:0] ALU_AND  = 5'd7;
    localparam logic [4:0] ALU_SRA  = 5'd13;
    localparam logic [4:0] ALU_FWD  = 5'd16;

    // RV32 major opcodes
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    // Writeback source selects
    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;

    // Immediate formats; SHAMT is the zero-extended shift amount of OP-IMM shifts
    typedef enum logic [2:0] {
        IMM_NONE  = 3'd0,
        IMM_I     = 3'd1,
        IMM_S     = 3'd2,
        IMM_B     = 3'd3,
        IMM_U     = 3'd4,
        IMM_J     = 3'd5,
        IMM_SHAMT = 3'd6
    } imm_fmt_e;

    // Contents of the ID/EX pipeline register; all-zero is a bubble
    typedef struct packed {
        logic        valid;
        logic        illegal;
        logic [4:0]  alu_op;
        logic        sub_op2;
        logic        op1_sel;
        logic        op2_sel;
        logic [31:0] imm;
        logic        mul_sel;
        logic [2:0]  mul_op;
        logic        branch;
        logic        jump;
        logic [2:0]  br_type;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic [1:0]  wb_sel;
        logic [31:0] pc;
        logic [4:0]  rd;
    } id_ex_t;

endpackage

// File: rtl/id_ex_decode_imm_gen.sv
// Combinational immediate generator for the RV32I I/S/B/U/J formats plus
// the shift-amount form; everything except SHAMT sign-extends from bit 31.
module imm_gen
    import id_ex_decode_pkg::*;
(
    input  logic [31:7] instr,
    input  imm_fmt_e    fmt,
    output logic [31:0] imm
);

    // Assemble the immediate for the selected format
    always_comb begin
        imm = 32'd0;
        case (fmt)
            IMM_I:     imm = {{20{instr[31]}}, instr[31:20]};
            IMM_S:     imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:     imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U:     imm = {instr[31:12], 12'd0};
            IMM_J:     imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            IMM_SHAMT: imm = {27'd0, instr[24:20]};
            default:   imm = 32'd0;
        endcase
    end

endmodule

// File: rtl/id_ex_decode.sv
// Instruction decode plus ID/EX pipeline register for an RV32IM core.
// Pipeline handshake: VALID_IN qualifies INSTR/PC_IN on each rising edge;
// STALL=1 holds the register, FLUSH=1 loads a bubble and overrides STALL,
// VALID_IN=0 also loads a bubble. VALID_OUT marks a live instruction in EX.
module id_ex_decode
    import id_ex_decode_pkg::*;
(
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic [31:0] INSTR,
    input  logic [31:0] PC_IN,
    input  logic        VALID_IN,
    input  logic        STALL,
    input  logic        FLUSH,
    output logic [4:0]  ALU_OP,
    output logic        SUB_OP2,
    output logic        OP1_SEL,
    output logic        OP2_SEL,
    output logic [31:0] IMM,
    output logic        MUL_SEL,
    output logic [2:0]  MUL_OP,
    output logic        BRANCH,
    output logic        JUMP,
    output logic [2:0]  BR_TYPE,
    output logic        REG_WRITE,
    output logic        MEM_READ,
    output logic        MEM_WRITE,
    output logic [1:0]  WB_SEL,
    output logic [31:0] PC_OUT,
    output logic [4:0]  RD,
    output logic        VALID_OUT,
    output logic        ILLEGAL
);

    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd_field;
    imm_fmt_e    imm_fmt;
    logic [31:0] imm;
    logic        legal;
    logic        writes_rd;
    id_ex_t      d;
    id_ex_t      q;

    assign opcode   = INSTR[6:0];
    assign f3       = INSTR[14:12];
    assign f7       = INSTR[31:25];
    assign rd_field = INSTR[11:7];

    // Pick the immediate format from the opcode (shifts use the shamt form)
    always_comb begin
        imm_fmt = IMM_NONE;
        case (opcode)
            OPC_OP_IMM:         imm_fmt = (f3 == 3'b001 || f3 == 3'b101) ? IMM_SHAMT : IMM_I;
            OPC_LOAD, OPC_JALR: imm_fmt = IMM_I;
            OPC_STORE:          imm_fmt = IMM_S;
            OPC_BRANCH:         imm_fmt = IMM_B;
            OPC_LUI, OPC_AUIPC: imm_fmt = IMM_U;
            OPC_JAL:            imm_fmt = IMM_J;
            default:            imm_fmt = IMM_NONE;
        endcase
    end

    imm_gen u_imm_gen (
        .instr (INSTR[31:7]),
        .fmt   (imm_fmt),
        .imm   (imm)
    );

    // Decode INSTR into the next ID/EX contents; illegal words keep only PC and the flag
    always_comb begin
        d         = '0;
        legal     = 1'b0;
        writes_rd = 1'b0;
        case (opcode)
            OPC_OP: begin
                writes_rd = 1'b1;
                if (f7 == 7'b0000001) begin
                    legal     = 1'b1;
                    d.mul_sel = 1'b1;
                    d.mul_op  = f3;
                    d.alu_op  = ALU_ADD;
                end else if (f7 == 7'b0000000 ||
                             (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101))) begin
                    legal     = 1'b1;
                    d.alu_op  = {1'b0, INSTR[30] & (f3 == 3'b101), f3};
                    d.sub_op2 = INSTR[30] & (f3 == 3'b000);
                end
            end
            OPC_OP_IMM: begin
                writes_rd = 1'b1;
                legal     = !(f3 == 3'b001 && f7 != 7'b0000000) &&
                            !(f3 == 3'b101 && f7 != 7'b0000000 && f7 != 7'b0100000);
                d.alu_op  = {1'b0, INSTR[30] & (f3 == 3'b101), f3};
                d.op2_sel = 1'b1;
            end
            OPC_LUI: begin
                writes_rd = 1'b1;
                legal     = 1'b1;
                d.alu_op  = ALU_FWD;
                d.op2_sel = 1'b1;
            end
            OPC_AUIPC: begin
                writes_rd = 1'b1;
                legal     = 1'b1;
                d.alu_op  = ALU_ADD;
                d.op1_sel = 1'b1;
                d.op2_sel = 1'b1;
            end
            OPC_JAL: begin
                writes_rd = 1'b1;
                legal     = 1'b1;
                d.op1_sel = 1'b1;
                d.op2_sel = 1'b1;
                d.jump    = 1'b1;
                d.wb_sel  = WB_PC4;
            end
            OPC_JALR: begin
                writes_rd = 1'b1;
                legal     = (f3 == 3'b000);
                d.op2_sel = 1'b1;
                d.jump    = 1'b1;
                d.wb_sel  = WB_PC4;
            end
            OPC_BRANCH: begin
                legal     = (f3 != 3'b010) && (f3 != 3'b011);
                d.sub_op2 = 1'b1;
                d.branch  = 1'b1;
                d.br_type = f3;
            end
            OPC_LOAD: begin
                writes_rd  = 1'b1;
                legal      = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
                             (f3 == 3'b100) || (f3 == 3'b101);
                d.op2_sel  = 1'b1;
                d.mem_read = 1'b1;
                d.wb_sel   = WB_MEM;
            end
            OPC_STORE: begin
                legal       = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
                d.op2_sel   = 1'b1;
                d.mem_write = 1'b1;
            end
            default: legal = 1'b0;
        endcase

        if (!legal) begin
            d         = '0;
            d.illegal = 1'b1;
        end else begin
            d.imm       = imm;
            d.rd        = writes_rd ? rd_field : 5'd0;
            d.reg_write = writes_rd && (rd_field != 5'd0);
        end
        d.valid = 1'b1;
        d.pc    = PC_IN;

        if (!VALID_IN) begin
            d = '0;
        end
    end

    // ID/EX register: flush beats stall, stall holds, otherwise load the decode
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            q <= '0;
        end else if (FLUSH) begin
            q <= '0;
        end else if (!STALL) begin
            q <= d;
        end
    end

    assign VALID_OUT = q.valid;
    assign ILLEGAL   = q.illegal;
    assign ALU_OP    = q.alu_op;
    assign SUB_OP2   = q.sub_op2;
    assign OP1_SEL   = q.op1_sel;
    assign OP2_SEL   = q.op2_sel;
    assign IMM       = q.imm;
    assign MUL_SEL   = q.mul_sel;
    assign MUL_OP    = q.mul_op;
    assign BRANCH    = q.branch;
    assign JUMP      = q.jump;
    assign BR_TYPE   = q.br_type;
    assign REG_WRITE = q.reg_write;
    assign MEM_READ  = q.mem_read;
    assign MEM_WRITE = q.mem_write;
    assign WB_SEL    = q.wb_sel;
    assign PC_OUT    = q.pc;
    assign RD        = q.rd;

endmodule
